// File: rtl/tmds_decoder.sv
// tmds_decoder: one TMDS receive channel. It aligns unaligned deserializer words by bit-slip, then undoes DC-balance and XOR/XNOR coding.
// Latency 2 cycles from word_in sample to data/ctrl/de. There is no backpressure: one word is accepted and one symbol is produced every cycle.
// Ports: clk_in, rst_n_in (async, active-low); word_in raw 10-bit word (bit 0 earliest);
//   data_out/ctrl_out/de_out decoded symbol; locked_out/offset_out alignment status.
module tmds_decoder #(
  parameter int LOCK_COUNT    = 4,
  parameter int SEARCH_CYCLES = 1024,
  parameter int LOSS_CYCLES   = 2048
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [9:0] word_in,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       locked_out,
  output logic [3:0] offset_out
);

  localparam int RW = $clog2(LOCK_COUNT + 1);
  localparam int SW = (SEARCH_CYCLES > 1) ? $clog2(SEARCH_CYCLES) : 1;
  localparam int LW = (LOSS_CYCLES > 1) ? $clog2(LOSS_CYCLES) : 1;
  localparam logic [RW-1:0] RUN_LAST    = RW'(LOCK_COUNT - 1);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_CYCLES - 1);
  localparam logic [LW-1:0] LOSS_LAST   = LW'(LOSS_CYCLES - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t        state, state_nxt;
  logic [3:0]    offset, offset_nxt, offset_wrap;
  logic [RW-1:0] run_cnt, run_nxt;
  logic [SW-1:0] search_cnt, search_nxt;
  logic [LW-1:0] loss_cnt, loss_nxt;

  logic [9:0] prev_q;
  logic [9:0] sym;
  logic       is_tok;
  logic [1:0] tok_val;

  logic [9:0] sym_q;
  logic       tok_q;
  logic [1:0] tok_val_q;
  logic       lock_q;
  logic [7:0] d;
  logic [7:0] dec;

  // Symbol window: prev_q holds the earlier word, so a slip of k takes
  // the upper 10-k bits of prev_q and the first k bits of the new word.
  always_comb begin
    sym = prev_q;
    case (offset)
      4'd1: sym = {word_in[0],   prev_q[9:1]};
      4'd2: sym = {word_in[1:0], prev_q[9:2]};
      4'd3: sym = {word_in[2:0], prev_q[9:3]};
      4'd4: sym = {word_in[3:0], prev_q[9:4]};
      4'd5: sym = {word_in[4:0], prev_q[9:5]};
      4'd6: sym = {word_in[5:0], prev_q[9:6]};
      4'd7: sym = {word_in[6:0], prev_q[9:7]};
      4'd8: sym = {word_in[7:0], prev_q[9:8]};
      4'd9: sym = {word_in[8:0], prev_q[9]};
      default: sym = prev_q;
    endcase
  end

  always_comb begin
    is_tok  = 1'b1;
    tok_val = 2'b00;
    case (sym)
      10'b1101010100: tok_val = 2'b00;
      10'b0010101011: tok_val = 2'b01;
      10'b0101010100: tok_val = 2'b10;
      10'b1010101011: tok_val = 2'b11;
      default:        is_tok  = 1'b0;
    endcase
  end

  assign offset_wrap = (offset == 4'd9) ? 4'd0 : offset + 4'd1;

  // Alignment FSM. Tokens are judged on the same edge that registers sym.
  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    run_nxt    = run_cnt;
    search_nxt = search_cnt;
    loss_nxt   = loss_cnt;
    case (state)
      SEARCH: begin
        search_nxt = search_cnt + 1'b1;
        run_nxt    = is_tok ? run_cnt + 1'b1 : '0;
        // Lock wins over a slip that falls due on the same cycle.
        if (is_tok && run_cnt == RUN_LAST) begin
          state_nxt  = LOCKED;
          loss_nxt   = '0;
          run_nxt    = '0;
          search_nxt = '0;
        end else if (search_cnt == SEARCH_LAST) begin
          offset_nxt = offset_wrap;
          run_nxt    = '0;
          search_nxt = '0;
        end
      end
      LOCKED: begin
        if (is_tok) begin
          loss_nxt = '0;
        end else if (loss_cnt == LOSS_LAST) begin
          state_nxt  = SEARCH;
          offset_nxt = offset_wrap;
          run_nxt    = '0;
          search_nxt = '0;
          loss_nxt   = '0;
        end else begin
          loss_nxt = loss_cnt + 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= SEARCH;
      offset     <= '0;
      run_cnt    <= '0;
      search_cnt <= '0;
      loss_cnt   <= '0;
      prev_q     <= '0;
      sym_q      <= '0;
      tok_q      <= 1'b0;
      tok_val_q  <= '0;
      lock_q     <= 1'b0;
    end else begin
      state      <= state_nxt;
      offset     <= offset_nxt;
      run_cnt    <= run_nxt;
      search_cnt <= search_nxt;
      loss_cnt   <= loss_nxt;
      prev_q     <= word_in;
      sym_q      <= sym;
      tok_q      <= is_tok;
      tok_val_q  <= tok_val;
      // The qualifier is the state before this edge's transition.
      lock_q     <= (state == LOCKED);
    end
  end

  // Undo DC-balance inversion, then transition minimization.
  always_comb begin
    d      = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = sym_q[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_out <= '0;
      ctrl_out <= '0;
      de_out   <= 1'b0;
    end else if (!lock_q) begin
      data_out <= '0;
      ctrl_out <= '0;
      de_out   <= 1'b0;
    end else if (tok_q) begin
      data_out <= '0;
      ctrl_out <= tok_val_q;
      de_out   <= 1'b0;
    end else begin
      // ctrl_out deliberately holds the last control value through video data.
      data_out <= dec;
      de_out   <= 1'b1;
    end
  end

  assign locked_out = (state == LOCKED);
  assign offset_out = offset;

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder (LOCK_COUNT=4, SEARCH_CYCLES=16, LOSS_CYCLES=32).
// Decoded outputs are checked through an expectation queue, 3 negedges after the word is driven.
// Alignment status is checked directly against cycle-exact expectations.
module tb_tmds_decoder;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  typedef struct packed {
    logic       chk;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
  } exp_t;

  logic       clk_in   = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [9:0] word_in  = '0;
  logic [7:0] data_out;
  logic [1:0] ctrl_out;
  logic       de_out;
  logic       locked_out;
  logic [3:0] offset_out;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [1:0] last_ctrl = 2'b00;

  tmds_decoder #(.LOCK_COUNT(4), .SEARCH_CYCLES(16), .LOSS_CYCLES(32)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .word_in(word_in),
    .data_out(data_out), .ctrl_out(ctrl_out), .de_out(de_out),
    .locked_out(locked_out), .offset_out(offset_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] dd, o;
    dd   = s[7:0] ^ {8{s[9]}};
    o    = '0;
    o[0] = dd[0];
    for (int i = 1; i < 8; i++) o[i] = dd[i] ^ dd[i-1] ^ ~s[8];
    return o;
  endfunction

  function automatic logic is_tok(input logic [9:0] w);
    return (w == T0) || (w == T1) || (w == T2) || (w == T3);
  endfunction

  function automatic logic [9:0] rand_data();
    logic [9:0] w;
    w = 10'($urandom);
    while (is_tok(w)) w = 10'($urandom);
    return w;
  endfunction

  task automatic test_reset();
    rst_n_in = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk_in);
      word_in = 10'($urandom);
      total++;
      if ({data_out, ctrl_out, de_out, locked_out, offset_out} !== 16'h0) begin
        bad++;
        $display("FAIL reset_state j=%0d: data=%h ctrl=%b de=%b locked=%b offset=%0d, want all 0",
                 j, data_out, ctrl_out, de_out, locked_out, offset_out);
      end
    end
  endtask

  task automatic test_aligned_lock();
    exp_t e;
    @(negedge clk_in);
    rst_n_in = 1'b1;
    word_in  = '0;
    for (int j = 0; j < 11; j++) begin
      @(negedge clk_in);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        if (e.chk) begin
          total++;
          if ({de_out, data_out, ctrl_out} !== {e.de, e.data, e.ctrl}) begin
            bad++;
            $display("FAIL aligned_out: de=%b data=%h ctrl=%b, want de=%b data=%h ctrl=%b",
                     de_out, data_out, ctrl_out, e.de, e.data, e.ctrl);
          end
        end
      end
      total++;
      if (locked_out !== (j >= 5)) begin
        bad++;
        $display("FAIL aligned_lock j=%0d: locked=%b want %b", j, locked_out, (j >= 5));
      end
      word_in = T0;
      sb.push_back(exp_t'({(j < 8), 1'b0, 8'h00, 2'b00}));
    end
    total++;
    if (offset_out !== 4'd0) begin
      bad++;
      $display("FAIL aligned_offset: offset=%0d want 0", offset_out);
    end
    sb.delete();
    last_ctrl = 2'b00;
  endtask

  task automatic test_data_decode();
    exp_t e, en;
    logic [9:0] wt[7];
    exp_t et[7];
    logic [9:0] w;
    wt = '{T1, 10'h100, 10'h2FF, 10'h1FF, T3, 10'h1FF, 10'h100};
    et = '{exp_t'({1'b1, 1'b0, 8'h00, 2'b01}), exp_t'({1'b1, 1'b1, 8'h00, 2'b01}),
           exp_t'({1'b1, 1'b1, 8'hFE, 2'b01}), exp_t'({1'b1, 1'b1, 8'h01, 2'b01}),
           exp_t'({1'b1, 1'b0, 8'h00, 2'b11}), exp_t'({1'b1, 1'b1, 8'h01, 2'b11}),
           exp_t'({1'b1, 1'b1, 8'h00, 2'b11})};
    for (int j = 0; j < 16; j++) begin
      @(negedge clk_in);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        if (e.chk) begin
          total++;
          if ({de_out, data_out, ctrl_out} !== {e.de, e.data, e.ctrl}) begin
            bad++;
            $display("FAIL data_decode: de=%b data=%h ctrl=%b, want de=%b data=%h ctrl=%b",
                     de_out, data_out, ctrl_out, e.de, e.data, e.ctrl);
          end
        end
      end
      if (j < 7) begin
        w  = wt[j];
        en = et[j];
      end else if (j < 13) begin
        w  = rand_data();
        en = exp_t'({1'b1, 1'b1, ref_decode(w), 2'b11});
      end else begin
        w  = T3;
        en = '0;
      end
      word_in = w;
      sb.push_back(en);
    end
    sb.delete();
    last_ctrl = 2'b11;
  endtask

  task automatic test_back_to_back();
    exp_t e, en;
    logic [9:0] toks[4];
    logic [9:0] w;
    logic [1:0] lc;
    int k;
    toks = '{T0, T1, T2, T3};
    lc   = last_ctrl;
    for (int j = 0; j < 27; j++) begin
      @(negedge clk_in);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        if (e.chk) begin
          total++;
          if ({de_out, data_out, ctrl_out} !== {e.de, e.data, e.ctrl}) begin
            bad++;
            $display("FAIL back_to_back: de=%b data=%h ctrl=%b, want de=%b data=%h ctrl=%b",
                     de_out, data_out, ctrl_out, e.de, e.data, e.ctrl);
          end
        end
      end
      if (j >= 24) begin
        w  = T0;
        en = '0;
      end else if ($urandom_range(0, 2) == 0) begin
        k  = $urandom_range(0, 3);
        w  = toks[k];
        lc = 2'(k);
        en = exp_t'({1'b1, 1'b0, 8'h00, lc});
      end else begin
        w  = rand_data();
        en = exp_t'({1'b1, 1'b1, ref_decode(w), lc});
      end
      word_in = w;
      sb.push_back(en);
    end
    sb.delete();
    last_ctrl = 2'b00;
  endtask

  task automatic test_keep_alive();
    exp_t e, en;
    logic [9:0] w;
    for (int j = 0; j < 1003; j++) begin
      @(negedge clk_in);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        if (e.chk) begin
          total++;
          if ({de_out, data_out, ctrl_out} !== {e.de, e.data, e.ctrl}) begin
            bad++;
            $display("FAIL keep_alive_out j=%0d: de=%b data=%h ctrl=%b, want de=%b data=%h ctrl=%b",
                     j, de_out, data_out, ctrl_out, e.de, e.data, e.ctrl);
          end
        end
      end
      total++;
      if (locked_out !== 1'b1) begin
        bad++;
        $display("FAIL keep_alive_lock j=%0d: locked=%b want 1", j, locked_out);
      end
      if (j >= 1000 || (j % 20) == 0) begin
        w  = T2;
        en = exp_t'({(j < 1000), 1'b0, 8'h00, 2'b10});
      end else begin
        w  = rand_data();
        en = exp_t'({1'b1, 1'b1, ref_decode(w), 2'b10});
      end
      word_in = w;
      sb.push_back(en);
    end
    sb.delete();
    last_ctrl = 2'b10;
  endtask

  task automatic test_loss();
    exp_t e;
    for (int j = 0; j < 48; j++) begin
      @(negedge clk_in);
      if (sb.size() == 3) begin
        e = sb.pop_front();
        if (e.chk) begin
          total++;
          if ({de_out, data_out, ctrl_out} !== {e.de, e.data, e.ctrl}) begin
            bad++;
            $display("FAIL loss_out j=%0d: de=%b data=%h ctrl=%b, want de=%b data=%h ctrl=%b",
                     j, de_out, data_out, ctrl_out, e.de, e.data, e.ctrl);
          end
        end
      end
      total++;
      if ({locked_out, offset_out} !== {(j < 33), (j < 33) ? 4'd0 : 4'd1}) begin
        bad++;
        $display("FAIL loss_lock j=%0d: locked=%b offset=%0d, want locked=%b offset=%0d",
                 j, locked_out, offset_out, (j < 33), (j < 33) ? 0 : 1);
      end
      word_in = 10'h100;
      if (j < 32) sb.push_back(exp_t'({1'b1, 1'b1, 8'h00, last_ctrl}));
      else        sb.push_back(exp_t'({(j < 45), 1'b0, 8'h00, 2'b00}));
    end
    sb.delete();
  endtask

  task automatic test_misaligned();
    logic [9:0] tk, w;
    logic [3:0] exp_off;
    tk = T0;
    w  = {tk[6:0], tk[9:7]};
    @(negedge clk_in);
    rst_n_in = 1'b0;
    word_in  = w;
    @(negedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk_in);
      exp_off = (n < 48) ? 4'(n / 16) : 4'd3;
      total++;
      if ({locked_out, offset_out} !== {(n >= 52), exp_off}) begin
        bad++;
        $display("FAIL misaligned n=%0d: locked=%b offset=%0d, want locked=%b offset=%0d",
                 n, locked_out, offset_out, (n >= 52), exp_off);
      end
    end
  endtask

  task automatic test_reset_mid_lock();
    @(negedge clk_in);
    total++;
    if ({locked_out, offset_out} !== {1'b1, 4'd3}) begin
      bad++;
      $display("FAIL mid_lock_pre: locked=%b offset=%0d, want locked=1 offset=3", locked_out, offset_out);
    end
    #2 rst_n_in = 1'b0;
    #1;
    total++;
    if ({data_out, ctrl_out, de_out, locked_out, offset_out} !== 16'h0) begin
      bad++;
      $display("FAIL mid_lock_reset: data=%h ctrl=%b de=%b locked=%b offset=%0d, want all 0",
               data_out, ctrl_out, de_out, locked_out, offset_out);
    end
    @(negedge clk_in);
  endtask

  task automatic test_wrap();
    logic [3:0] exp_off;
    word_in  = '0;
    rst_n_in = 1'b1;
    for (int n = 1; n <= 175; n++) begin
      @(negedge clk_in);
      exp_off = (n < 160) ? 4'(n / 16) : 4'd0;
      total++;
      if ({locked_out, offset_out} !== {(n >= 165), exp_off}) begin
        bad++;
        $display("FAIL wrap n=%0d: locked=%b offset=%0d, want locked=%b offset=%0d",
                 n, locked_out, offset_out, (n >= 165), exp_off);
      end
      if (n == 160) word_in = T0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_aligned_lock();
    test_data_decode();
    test_back_to_back();
    test_keep_alive();
    test_loss();
    test_misaligned();
    test_reset_mid_lock();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
